// File: rtl/data_memory_lsu_if.sv
// -----------------------------------------------------------------------------
// data_memory_lsu_if
// Purpose : request/response bundle between the core's load/store path and the
//           data memory.
// Signals : mem_read, mem_write  - load / store request, sampled at posedge
//           funct3               - RV32I size/sign code (0=B,1=H,2=W,4=BU,5=HU)
//           address              - byte address, ADDR_W bits
//           write_data           - right-justified store data
//           read_data            - registered, extended load result
//           read_valid           - one-cycle pulse, read_data updated
//           misaligned           - one-cycle pulse, previous request rejected
//           busy                 - high while the clear sequencer runs
// Modports: master (core / bench side), slave (memory side)
// -----------------------------------------------------------------------------
interface data_memory_lsu_if #(
  parameter int ADDR_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              misaligned;
  logic              busy;

  modport master (
    output mem_read, mem_write, funct3, address, write_data,
    input  read_data, read_valid, misaligned, busy
  );

  modport slave (
    input  mem_read, mem_write, funct3, address, write_data,
    output read_data, read_valid, misaligned, busy
  );
endinterface

// File: rtl/data_memory_lsu.sv
// -----------------------------------------------------------------------------
// data_memory_lsu
// Purpose : byte-addressed 32-bit data memory with RV32I sub-word loads and
//           stores, misalignment/illegal-code detection, and a clear sequencer
//           that zeroes one word per cycle after reset.
// Ports   : i_clk   - rising-edge clock
//           i_reset - asynchronous, active-high reset
//           bus     - data_memory_lsu_if.slave (request/response bundle)
// -----------------------------------------------------------------------------
module data_memory_lsu #(
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  data_memory_lsu_if.slave    bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  logic [31:0] r_mem [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_clear_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [31:0]        r_read_data;
  logic               r_read_valid;
  logic               r_misaligned;
  logic               r_busy;

  logic [IDX_W-1:0]   w_req_idx;
  logic [1:0]         w_lane;
  logic [31:0]        w_rd_word;
  logic [3:0]         w_mem_be;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [31:0]        w_mem_wdata;
  logic               w_load_fire;
  logic               w_reject;

  // Loads: B/BU any lane, H/HU even address, W word-aligned; 3/6/7 illegal.
  function automatic logic f_load_legal(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'd0, 3'd4: f_load_legal = 1'b1;
      3'd1, 3'd5: f_load_legal = (lane[0] == 1'b0);
      3'd2:       f_load_legal = (lane == 2'd0);
      default:    f_load_legal = 1'b0;
    endcase
  endfunction

  // Stores only have SB/SH/SW; the unsigned codes are illegal here.
  function automatic logic f_store_legal(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'd0:    f_store_legal = 1'b1;
      3'd1:    f_store_legal = (lane[0] == 1'b0);
      3'd2:    f_store_legal = (lane == 2'd0);
      default: f_store_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'd0:    f_store_be = 4'b0001 << lane;
      3'd1:    f_store_be = lane[1] ? 4'b1100 : 4'b0011;
      3'd2:    f_store_be = 4'b1111;
      default: f_store_be = 4'b0000;
    endcase
  endfunction

  // Replicate the right-justified data so every enabled lane sees its byte.
  function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    f_store_data = {4{wd[7:0]}};
      3'd1:    f_store_data = {2{wd[15:0]}};
      default: f_store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    f_extend = {{24{b[7]}}, b};
      3'd1:    f_extend = {{16{h[15]}}, h};
      3'd2:    f_extend = word;
      3'd4:    f_extend = {24'h000000, b};
      3'd5:    f_extend = {16'h0000, h};
      default: f_extend = 32'h0000_0000;
    endcase
  endfunction

  assign w_req_idx = bus.address[ADDR_W-1:2];
  assign w_lane    = bus.address[1:0];
  assign w_rd_word = r_mem[w_req_idx];

  // Next-state and memory-port control; reads win over simultaneous writes.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_clear_ptr;
    w_mem_be    = 4'b0000;
    w_mem_idx   = w_req_idx;
    w_mem_wdata = 32'h0000_0000;
    w_load_fire = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_be  = 4'b1111;
        w_mem_idx = r_clear_ptr;
        w_ptr_nxt = r_clear_ptr + 1'b1;
        if (r_clear_ptr == IDX_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (bus.mem_read) begin
          if (f_load_legal(bus.funct3, w_lane)) begin
            w_load_fire = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end else if (bus.mem_write) begin
          if (f_store_legal(bus.funct3, w_lane)) begin
            w_mem_be    = f_store_be(bus.funct3, w_lane);
            w_mem_wdata = f_store_data(bus.funct3, bus.write_data);
          end else begin
            w_reject = 1'b1;
          end
        end else begin
          w_reject = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, clear pointer and registered outputs with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clear_ptr  <= '0;
      r_read_data  <= 32'h0000_0000;
      r_read_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_busy       <= CLEAR_ON_RESET;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_ptr  <= w_ptr_nxt;
      r_read_valid <= w_load_fire;
      r_misaligned <= w_reject;
      r_busy       <= (w_state_nxt == ST_CLEAR);
      if (w_load_fire) begin
        r_read_data <= f_extend(w_rd_word, w_lane, bus.funct3);
      end
    end
  end

  // Byte-lane memory write port; held off while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.misaligned = r_misaligned;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_data_memory_lsu.sv
// -----------------------------------------------------------------------------
// tb_data_memory_lsu
// Purpose : self-checking bench for data_memory_lsu (ADDR_W=6, 16 words).
//           Directed vector table, hand-written reset/clear sequences and a
//           randomized phase checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_data_memory_lsu;

  localparam int AW = 6;
  localparam int NB = 64;

  logic clk;
  logic rst;

  data_memory_lsu_if #(.ADDR_W(AW)) bus ();

  data_memory_lsu #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain byte array plus the expected output registers.
  logic [7:0]  ref_b [NB];
  logic [31:0] exp_rd;
  logic        exp_rv;
  logic        exp_mis;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_rv;
    logic        e_mis;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) ref_b[i] = 8'h00;
    exp_rd  = 32'h0;
    exp_rv  = 1'b0;
    exp_mis = 1'b0;
  endtask

  task automatic model_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [5:0] a, input logic [31:0] wd);
    int   size;
    bit   sgn;
    bit   legal;
    logic [31:0] v;
    logic signed [31:0] sv;
    exp_rv  = 1'b0;
    exp_mis = 1'b0;
    if (rd || wr) begin
      legal = 1'b1;
      sgn   = 1'b0;
      size  = 1;
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: begin size = 1; legal = rd; end
        3'd5: begin size = 2; legal = rd; end
        default: legal = 1'b0;
      endcase
      if (legal && (int'(a) % size) != 0) legal = 1'b0;
      if (!legal) begin
        exp_mis = 1'b1;
      end else if (rd) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
        if (sgn && size < 4) begin
          sv = v << (32 - 8 * size);
          sv = sv >>> (32 - 8 * size);
          v  = sv;
        end
        exp_rd = v;
        exp_rv = 1'b1;
      end else begin
        for (int i = 0; i < size; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
      end
    end
  endtask

  // Present one request for exactly one posedge; outputs sampled at the negedge.
  task automatic step(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [5:0] a, input logic [31:0] wd);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.address    = a;
    bus.write_data = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; reset must already be low.
  task automatic count_busy(output int cnt, output bit side_effect);
    cnt = 0;
    side_effect = 1'b0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (bus.read_valid !== 1'b0 || bus.misaligned !== 1'b0) side_effect = 1'b1;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic add(input logic rd, input logic wr, input logic [2:0] f3, input logic [5:0] a,
                     input logic [31:0] wd, input logic [31:0] e_rd, input logic e_rv,
                     input logic e_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
    v.e_rd = e_rd; v.e_rv = e_rv; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  int  bcnt;
  bit  bside;

  initial begin
    // Directed vectors; starts with read_data = 0 and memory cleared.
    add(1'b0, 1'b1, 3'd2, 6'h08, 32'h11223344, 32'h00000000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 6'h09, 32'h000000AA, 32'h00000000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 6'h0A, 32'h0000BEEF, 32'h00000000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 6'h08, 32'h00000000, 32'hBEEFAA44, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 6'h0C, 32'h80FF7F01, 32'hBEEFAA44, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 6'h0E, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd4, 6'h0E, 32'h00000000, 32'h000000FF, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd1, 6'h0E, 32'h00000000, 32'hFFFF80FF, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd5, 6'h0C, 32'h00000000, 32'h00007F01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 6'h0C, 32'h00000000, 32'h00000001, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 6'h10, 32'h55667788, 32'h00000001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 6'h11, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    add(1'b1, 1'b0, 3'd1, 6'h03, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
    add(1'b1, 1'b0, 3'd3, 6'h10, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
    add(1'b0, 1'b1, 3'd4, 6'h10, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    add(1'b1, 1'b0, 3'd2, 6'h10, 32'h00000000, 32'h55667788, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd2, 6'h10, 32'h00000000, 32'h55667788, 1'b0, 1'b0);
    add(1'b1, 1'b1, 3'd2, 6'h04, 32'h12345678, 32'h00000000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd2, 6'h04, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 6'h04, 32'hA5A55A5A, 32'h00000000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 6'h04, 32'h00000000, 32'hA5A55A5A, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd5, 6'h06, 32'h00000000, 32'h0000A5A5, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 6'h05, 32'h00000000, 32'h0000005A, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 6'h07, 32'h00000000, 32'hFFFFFFA5, 1'b1, 1'b0);

    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0;
    bus.address = '0; bus.write_data = 32'h0;
    model_reset();

    // Power-on reset and initial clear.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset read_data", bus.read_data, 32'h0);
    chk("reset read_valid", 32'(bus.read_valid), 32'h0);
    chk("reset misaligned", 32'(bus.misaligned), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    count_busy(bcnt, bside);
    chk("initial clear cycles", bcnt, 32'd16);

    // Preload word 5, then reset and hold a store during the clear.
    step(1'b0, 1'b1, 3'd2, 6'h14, 32'hDEADBEEF);
    step(1'b1, 1'b0, 3'd2, 6'h14, 32'h0);
    chk("preload readback", bus.read_data, 32'hDEADBEEF);
    idle();
    rst = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b1; bus.funct3 = 3'd2; bus.address = 6'h14; bus.write_data = 32'hFFFFFFFF;
    rst = 1'b0;
    count_busy(bcnt, bside);
    chk("clear busy cycles", bcnt, 32'd16);
    chk("clear no side effect", 32'(bside), 32'h0);
    step(1'b1, 1'b0, 3'd2, 6'h14, 32'h0);
    chk("clear LW data", bus.read_data, 32'h0);
    chk("clear LW valid", 32'(bus.read_valid), 32'h1);
    step(1'b0, 1'b0, 3'd2, 6'h14, 32'h0);
    chk("valid self-clear", 32'(bus.read_valid), 32'h0);

    // Table-driven directed vectors; model tracks the same operations.
    model_reset();
    foreach (tbl[i]) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd);
      model_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd);
      chk($sformatf("vec%0d read_data", i), bus.read_data, tbl[i].e_rd);
      chk($sformatf("vec%0d read_valid", i), 32'(bus.read_valid), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d misaligned", i), 32'(bus.misaligned), 32'(tbl[i].e_mis));
    end

    // Reset one cycle after a load: outputs drop asynchronously.
    step(1'b1, 1'b0, 3'd2, 6'h08, 32'h0);
    idle();
    chk("pre-reset load valid", 32'(bus.read_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async reset read_data", bus.read_data, 32'h0);
    chk("async reset read_valid", 32'(bus.read_valid), 32'h0);
    chk("async reset busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid-clear busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid-clear reset busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(bcnt, bside);
    chk("restarted clear cycles", bcnt, 32'd16);
    model_reset();
    step(1'b1, 1'b0, 3'd2, 6'h08, 32'h0);
    chk("after restart word2", bus.read_data, 32'h0);
    step(1'b1, 1'b0, 3'd2, 6'h3C, 32'h0);
    chk("after restart word15", bus.read_data, 32'h0);
    chk("after restart valid", 32'(bus.read_valid), 32'h1);

    // Randomized phase against the reference model.
    for (int k = 0; k < 300; k++) begin
      int          op;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [5:0]  a;
      logic [31:0] wd;
      op = int'($urandom_range(0, 9));
      rd = (op <= 3) || (op == 8);
      wr = (op >= 4 && op <= 8);
      f3 = 3'($urandom_range(0, 7));
      a  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      step(rd, wr, f3, a, wd);
      model_op(rd, wr, f3, a, wd);
      chk($sformatf("rand%0d read_data", k), bus.read_data, exp_rd);
      chk($sformatf("rand%0d read_valid", k), 32'(bus.read_valid), 32'(exp_rv));
      chk($sformatf("rand%0d misaligned", k), 32'(bus.misaligned), 32'(exp_mis));
    end
    chk("busy low after random", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
